// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
//   - fetch_state_e : FSM state encoding (BOOT, FETCH, IMM)
//   - LONG_PREFIX   : top-bit pattern that marks a two-word instruction
//   - LONG_PREFIX_W : number of top bits the prefix occupies ([W-1 -: 2])
//   - DEF_RESET_VEC : default address of the boot-PC word
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_IMM   = 2'b10
  } fetch_state_e;

  localparam logic [1:0]  LONG_PREFIX   = 2'b11;
  localparam int          LONG_PREFIX_W = 2;
  localparam logic [15:0] DEF_RESET_VEC = 16'h0000;

endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// pc_next_sel: combinational next-PC selection for the fetch stage.
// Ports:
//   state       in  current fetch FSM state
//   flush       in  redirect request (wins over stall)
//   stall       in  hold request
//   pc          in  current PC register
//   boot_pc     in  memory word read from the reset vector (used in BOOT)
//   redirect_pc in  redirect target
//   pc_next     out value the PC register takes at the next edge
//   pc_inc      out pc + 1, modulo 2^AW
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int AW = 16
) (
  input  fetch_state_e  state,
  input  logic          flush,
  input  logic          stall,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] boot_pc,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] pc_next,
  output logic [AW-1:0] pc_inc
);

  // Next-PC mux: BOOT ignores stall/flush; otherwise flush > stall > advance.
  always_comb begin
    pc_inc  = pc + {{(AW-1){1'b0}}, 1'b1};
    pc_next = pc;
    case (state)
      ST_BOOT: begin
        pc_next = boot_pc;
      end
      ST_FETCH, ST_IMM: begin
        if (flush) begin
          pc_next = redirect_pc;
        end else if (stall) begin
          pc_next = pc;
        end else begin
          pc_next = pc_inc;
        end
      end
      default: begin
        // Illegal state: keep the PC while the FSM recovers.
        pc_next = pc;
      end
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch feeding the IF/ID pipeline register.
// Boots the PC from the word at RESET_VEC, then fetches one- or two-word
// instructions (two-word when the top two bits are 2'b11).
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   stall              hold PC, FSM and IF/ID
//   flush, redirect_pc drop in-flight fetch and restart at redirect_pc
//   imem_addr/data     combinational-read instruction memory
//   pc                 current PC register
//   ifid_*             IF/ID register; fields are meaningful only when ifid_valid=1
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int            W         = 16,
  parameter int            AW        = 16,
  parameter logic [AW-1:0] RESET_VEC = AW'(DEF_RESET_VEC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] imem_addr,
  input  logic [W-1:0]  imem_data,
  output logic [AW-1:0] pc,
  output logic [W-1:0]  ifid_instr,
  output logic [W-1:0]  ifid_imm,
  output logic [AW-1:0] ifid_pc_next,
  output logic          ifid_valid
);

  fetch_state_e  state_r, state_nxt_s;
  logic [AW-1:0] pc_r, pc_nxt_s, pc_inc_s, boot_pc_s;
  logic [W-1:0]  first_word_r, first_nxt_s;
  logic [W-1:0]  ifid_instr_r, instr_nxt_s;
  logic [W-1:0]  ifid_imm_r, imm_nxt_s;
  logic [AW-1:0] ifid_pc_next_r, pcn_nxt_s;
  logic          ifid_valid_r, valid_nxt_s;
  logic          is_long_s;

  assign is_long_s = (imem_data[W-1 -: LONG_PREFIX_W] == LONG_PREFIX);
  assign boot_pc_s = AW'(imem_data);
  assign imem_addr = (state_r == ST_BOOT) ? RESET_VEC : pc_r;

  assign pc           = pc_r;
  assign ifid_instr   = ifid_instr_r;
  assign ifid_imm     = ifid_imm_r;
  assign ifid_pc_next = ifid_pc_next_r;
  assign ifid_valid   = ifid_valid_r;

  pc_next_sel #(.AW(AW)) u_pc_next_sel (
    .state       (state_r),
    .flush       (flush),
    .stall       (stall),
    .pc          (pc_r),
    .boot_pc     (boot_pc_s),
    .redirect_pc (redirect_pc),
    .pc_next     (pc_nxt_s),
    .pc_inc      (pc_inc_s)
  );

  // Next-state and IF/ID load logic; unlisted fields hold their value.
  always_comb begin
    state_nxt_s = state_r;
    first_nxt_s = first_word_r;
    instr_nxt_s = ifid_instr_r;
    imm_nxt_s   = ifid_imm_r;
    pcn_nxt_s   = ifid_pc_next_r;
    valid_nxt_s = ifid_valid_r;
    case (state_r)
      ST_BOOT: begin
        state_nxt_s = ST_FETCH;
        valid_nxt_s = 1'b0;
      end
      ST_FETCH, ST_IMM: begin
        if (flush) begin
          // Any half-fetched two-word instruction is abandoned here.
          state_nxt_s = ST_FETCH;
          first_nxt_s = {W{1'b0}};
          valid_nxt_s = 1'b0;
        end else if (stall) begin
          state_nxt_s = state_r;
        end else if (state_r == ST_IMM) begin
          instr_nxt_s = first_word_r;
          imm_nxt_s   = imem_data;
          pcn_nxt_s   = pc_inc_s;
          valid_nxt_s = 1'b1;
          state_nxt_s = ST_FETCH;
        end else if (is_long_s) begin
          // Opcode word captured; emit a bubble while the immediate is read.
          first_nxt_s = imem_data;
          valid_nxt_s = 1'b0;
          state_nxt_s = ST_IMM;
        end else begin
          instr_nxt_s = imem_data;
          imm_nxt_s   = {W{1'b0}};
          pcn_nxt_s   = pc_inc_s;
          valid_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_FETCH;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_BOOT;
      pc_r           <= {AW{1'b0}};
      first_word_r   <= {W{1'b0}};
      ifid_instr_r   <= {W{1'b0}};
      ifid_imm_r     <= {W{1'b0}};
      ifid_pc_next_r <= {AW{1'b0}};
      ifid_valid_r   <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      pc_r           <= pc_nxt_s;
      first_word_r   <= first_nxt_s;
      ifid_instr_r   <= instr_nxt_s;
      ifid_imm_r     <= imm_nxt_s;
      ifid_pc_next_r <= pcn_nxt_s;
      ifid_valid_r   <= valid_nxt_s;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized check of fetch_stage against an
// instruction-level reference model (boot flag, PC, pending opcode word).
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] pc;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_imm;
  logic [15:0] ifid_pc_next;
  logic        ifid_valid;

  logic [15:0] mem [0:65535];

  int n_tests;
  int n_fail;

  // Reference model state
  bit          m_booted;
  bit          m_pending;
  logic [15:0] m_pc;
  logic [15:0] m_first;
  logic [15:0] e_instr;
  logic [15:0] e_imm;
  logic [15:0] e_pcn;
  bit          e_valid;

  assign imem_data = mem[imem_addr];

  fetch_stage #(.W(16), .AW(16), .RESET_VEC(16'h0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .pc           (pc),
    .ifid_instr   (ifid_instr),
    .ifid_imm     (ifid_imm),
    .ifid_pc_next (ifid_pc_next),
    .ifid_valid   (ifid_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_booted  = 1'b0;
    m_pending = 1'b0;
    m_pc      = 16'h0000;
    m_first   = 16'h0000;
    e_instr   = 16'h0000;
    e_imm     = 16'h0000;
    e_pcn     = 16'h0000;
    e_valid   = 1'b0;
  endtask

  // Apply one clock edge's worth of the instruction-level fetch rules.
  task automatic model_edge();
    logic [15:0] d;
    d = mem[m_booted ? m_pc : 16'h0000];
    if (!m_booted) begin
      m_pc     = d;
      m_booted = 1'b1;
      e_valid  = 1'b0;
    end else if (flush) begin
      m_pc      = redirect_pc;
      m_pending = 1'b0;
      e_valid   = 1'b0;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (m_pending) begin
      e_instr   = m_first;
      e_imm     = d;
      e_pcn     = m_pc + 16'd1;
      e_valid   = 1'b1;
      m_pc      = m_pc + 16'd1;
      m_pending = 1'b0;
    end else if (d[15:14] == 2'b11) begin
      m_first   = d;
      m_pending = 1'b1;
      e_valid   = 1'b0;
      m_pc      = m_pc + 16'd1;
    end else begin
      e_instr = d;
      e_imm   = 16'h0000;
      e_pcn   = m_pc + 16'd1;
      e_valid = 1'b1;
      m_pc    = m_pc + 16'd1;
    end
  endtask

  task automatic check_outputs();
    check_val("pc", 32'(pc), 32'(m_pc));
    check_val("ifid_valid", 32'(ifid_valid), 32'(e_valid));
    check_val("ifid_instr", 32'(ifid_instr), 32'(e_instr));
    check_val("ifid_imm", 32'(ifid_imm), 32'(e_imm));
    check_val("ifid_pc_next", 32'(ifid_pc_next), 32'(e_pcn));
  endtask

  // Called at a negedge: drive inputs, check address, advance one edge, check.
  task automatic step(input bit s, input bit f, input logic [15:0] r);
    stall       = s;
    flush       = f;
    redirect_pc = r;
    #1;
    check_val("imem_addr", 32'(imem_addr), 32'(m_booted ? m_pc : 16'h0000));
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // Assert reset mid-cycle, verify immediate effect, release on a negedge.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_val("rst_imem_addr", 32'(imem_addr), 32'h0000);
    @(negedge clk);
    stall = 1'b0;
    flush = 1'b0;
    rst   = 1'b1;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect_pc = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    model_reset();

    // Reset state and boot + one-word stream
    mem[16'h0000] = 16'h0010;
    mem[16'h0010] = 16'h1234;
    mem[16'h0011] = 16'h2222;
    @(negedge clk);
    check_outputs();
    check_val("reset_valid", 32'(ifid_valid), 32'h0);
    rst = 1'b1;
    step(1'b1, 1'b1, 16'h0077);  // stall/flush ignored in boot
    check_val("boot_pc", 32'(pc), 32'h0010);
    check_val("boot_valid", 32'(ifid_valid), 32'h0);
    step(1'b0, 1'b0, 16'h0000);
    check_val("w1_instr", 32'(ifid_instr), 32'h1234);
    check_val("w1_pcn", 32'(ifid_pc_next), 32'h0011);
    step(1'b0, 1'b0, 16'h0000);
    check_val("w2_instr", 32'(ifid_instr), 32'h2222);
    check_val("w2_pcn", 32'(ifid_pc_next), 32'h0012);

    // Two-word with a 3-cycle stall while in IMM
    do_reset();
    mem[16'h0010] = 16'hC005;
    mem[16'h0011] = 16'hABCD;
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    check_val("long_bubble", 32'(ifid_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'h0000);
      check_val("stall_pc", 32'(pc), 32'h0011);
    end
    step(1'b0, 1'b0, 16'h0000);
    check_val("long_instr", 32'(ifid_instr), 32'hC005);
    check_val("long_imm", 32'(ifid_imm), 32'hABCD);
    check_val("long_pcn", 32'(ifid_pc_next), 32'h0012);
    check_val("long_valid", 32'(ifid_valid), 32'h1);

    // Flush beats stall in IMM; C005 never delivered
    do_reset();
    mem[16'h0040] = 16'h0001;
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 16'h0040);
    check_val("flush_pc", 32'(pc), 32'h0040);
    check_val("flush_valid", 32'(ifid_valid), 32'h0);
    step(1'b0, 1'b0, 16'h0000);
    check_val("post_flush_instr", 32'(ifid_instr), 32'h0001);
    check_val("post_flush_imm", 32'(ifid_imm), 32'h0000);

    // PC wrap at 16'hFFFF, then asynchronous reset mid-cycle
    mem[16'hFFFF] = 16'h1111;
    step(1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 16'h0000);
    check_val("wrap_pcn", 32'(ifid_pc_next), 32'h0000);
    check_val("wrap_pc", 32'(pc), 32'h0000);
    check_val("wrap_instr", 32'(ifid_instr), 32'h1111);
    do_reset();
    check_val("async_rst_pc", 32'(pc), 32'h0000);

    // Randomized program, stalls, flushes and occasional resets
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), 16'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the decode stage and drives the IF/ID pipeline register that decode consumes.
- Owns the PC and loads the start address from the reset vector word after reset.
- Fetches one- or two-word instructions from a combinational-read instruction memory.
- Honours stall (hazard unit) and flush/redirect (branch resolution).

Parameters:
W, 16, instruction/data word width
AW, 16, instruction address (PC) width
RESET_VEC, 0, address whose memory word holds the boot PC

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  hold PC, FSM and IF/ID contents
flush  in  1  discard in-flight fetch, redirect PC
redirect_pc  in  AW  target PC used when flush=1
imem_addr  out  AW  instruction memory address (combinational)
imem_data  in  W  instruction memory word, valid same cycle as imem_addr
pc  out  AW  current PC register
ifid_instr  out  W  first (opcode) word to decode
ifid_imm  out  W  second word of two-word instruction, else 0
ifid_pc_next  out  AW  address following the delivered instruction
ifid_valid  out  1  1 = IF/ID holds a real instruction, 0 = bubble

Behaviour:
- Reset (rst=0, asynchronous):
  - state=BOOT, pc=0, first_word=0.
  - ifid_instr=0, ifid_imm=0, ifid_pc_next=0, ifid_valid=0.
- Two-word instruction: imem_data[W-1:W-2]==2'b11; otherwise one word.
- imem_addr:
  - BOOT: RESET_VEC.
  - FETCH/IMM: pc.
- BOOT:
  - pc<=imem_data; state<=FETCH; ifid_valid stays 0.
  - stall and flush are ignored.
  - First decode-visible instruction appears 2 edges after reset release.
- Priority in FETCH/IMM: flush > stall > normal.
- Flush (any FETCH/IMM cycle):
  - pc<=redirect_pc; state<=FETCH; ifid_valid<=0.
  - A pending first_word is dropped.
- Stall without flush: pc, state, first_word and all ifid_* hold their values.
- FETCH, one-word:
  - ifid_instr<=imem_data; ifid_imm<=0; ifid_pc_next<=pc+1; ifid_valid<=1.
  - pc<=pc+1.
- FETCH, two-word:
  - first_word<=imem_data; pc<=pc+1; ifid_valid<=0 (bubble); state<=IMM.
- IMM:
  - ifid_instr<=first_word; ifid_imm<=imem_data; ifid_pc_next<=pc+1; ifid_valid<=1.
  - pc<=pc+1; state<=FETCH.
- Throughput:
  - One-word instructions: 1 per cycle.
  - Two-word instructions: 1 per 2 cycles.
- Arithmetic: pc+1 is modulo 2^AW. PC 16'hFFFF fetches, then wraps to 0 with no flag.
- When ifid_valid=0, the ifid_instr/ifid_imm/ifid_pc_next fields keep their previous values. Decode must qualify them with ifid_valid.
- Reset asserted mid-operation (any state) returns immediately to reset values; a partially fetched two-word instruction is lost.
- Illegal state encoding recovers to FETCH on the next edge with ifid_valid<=0.

Decomposition:
- Shared package fetch_pkg holds:
  - State encoding: BOOT, FETCH, IMM (2-bit).
  - LONG_PREFIX=2'b11 and its bit position.
  - Default RESET_VEC.
- One sub-module, pc_next_sel: combinational next-PC mux (reset vector data / redirect_pc / pc / pc+1), selected by state, flush, stall.

Test Plan:
- Boot: RESET_VEC=0, imem[0]=16'h0010, release rst → edge 1 pc=16'h0010, ifid_valid=0; imem_addr=16'h0010 thereafter.
- One-word stream: imem[0x10]=16'h1234, imem[0x11]=16'h2222 → consecutive edges give ifid_instr=1234/2222, ifid_pc_next=0x11/0x12, ifid_valid=1,1.
- Two-word: imem[0x10]=16'hC005, imem[0x11]=16'hABCD → edge A ifid_valid=0; edge B ifid_instr=C005, ifid_imm=ABCD, ifid_pc_next=0x12, ifid_valid=1.
- Stall: assert stall 3 cycles while in IMM → pc, all ifid_* unchanged for 3 edges; after release, completes as in the two-word case.
- Flush priority: in IMM assert flush=1 and stall=1 with redirect_pc=16'h0040 → next edge pc=0x40, state FETCH, ifid_valid=0; C005 never delivered.
- Wrap and async reset: pc=16'hFFFF with a one-word instruction → ifid_pc_next=0, pc=0; then drop rst mid-cycle → all outputs 0 immediately, before the next clk edge.
